// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath write enables and handshakes, traps on illegal opcodes and memory timeouts.
module multicycle_controller #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] retired
);

  localparam int unsigned WaitW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StTrap   = 3'd6,
    StBad    = 3'd7
  } state_e;

  state_e           state_q;
  state_e           boundary;
  logic [WaitW-1:0] wait_q;
  logic             wait_expired;
  logic             trap_q;
  logic [1:0]       cause_q;
  logic [31:0]      retired_q;

  function automatic logic legal_op(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
      7'b1100011, 7'b1101111, 7'b1100111: legal_op = 1'b1;
      default:                            legal_op = 1'b0;
    endcase
  endfunction

  assign boundary     = run ? StFetch : StIdle;
  assign wait_expired = (wait_q == WaitW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'b00;
      retired_q <= '0;
    end else begin
      retired_q <= retired_q + 32'(pc_we);
      // Counter idles at zero so every entry to FETCH/MEM starts a fresh count.
      wait_q    <= '0;
      case (state_q)
        StIdle: if (run) state_q <= StFetch;
        StFetch: begin
          if (imem_ready) begin
            state_q <= StDecode;
          end else if (wait_expired) begin
            state_q <= StTrap;
            trap_q  <= 1'b1;
            cause_q <= 2'b10;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StDecode: begin
          if (legal_op(opcode)) begin
            state_q <= StExec;
          end else begin
            state_q <= StTrap;
            trap_q  <= 1'b1;
            cause_q <= 2'b01;
          end
        end
        StExec: begin
          if (MemRead || MemWrite) state_q <= StMem;
          else if (Branch)         state_q <= boundary;
          else                     state_q <= StWb;
        end
        StMem: begin
          if (dmem_ready) begin
            state_q <= MemWrite ? boundary : StWb;
          end else if (wait_expired) begin
            state_q <= StTrap;
            trap_q  <= 1'b1;
            cause_q <= 2'b11;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StWb:   state_q <= boundary;
        StTrap: state_q <= StTrap;
        default: begin
          state_q <= StTrap;
          trap_q  <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    mdr_we   = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'b00;
    wb_sel   = 2'b00;
    case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      StExec: begin
        if (!(MemRead || MemWrite) && Branch) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken ? 2'b01 : 2'b00;
        end
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = MemWrite;
        if (dmem_ready) begin
          if (MemWrite) pc_we  = 1'b1;
          else          mdr_we = 1'b1;
        end
      end
      StWb: begin
        rf_we = RegWrite;
        pc_we = 1'b1;
        if (Jump)         wb_sel = 2'b10;
        else if (MemRead) wb_sel = 2'b01;
        if (opcode == 7'b1101111)      pc_sel = 2'b01;
        else if (opcode == 7'b1100111) pc_sel = 2'b10;
      end
      default: ;
    endcase
  end

  assign state      = state_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule
